// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: state encoding, SUMP opcodes
// and defaults used by the decoder and its timeout counter.
package uart_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_RUN       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_SET_DIV   = 8'h80;
  localparam logic [7:0] OP_SET_CNT   = 8'h81;
  localparam logic [7:0] OP_SET_FLAGS = 8'h82;

  // Opcodes with this bit set carry argument bytes.
  localparam int LONG_BIT = 7;

  localparam int TO_N_DEFAULT = 100000;

endpackage

// File: rtl/uart_cmd_decoder_timeout.sv
// Saturating up-counter with synchronous clear; reports the terminal count and
// the enabled step that reaches it.
module cmd_timeout #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic hit
);

  localparam logic [W-1:0] TERM = W'(N - 1);
  localparam logic [W-1:0] PRE  = W'(N - 2);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != TERM)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc  = (cnt_reg == TERM);
  // hit: this enabled step lands the counter on its terminal value.
  assign hit = en && !clr && (cnt_reg == PRE);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into SUMP short/long commands and hands them out on a
// valid/ready interface; byte errors and inter-byte timeouts drop the command.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int TO_N = TO_N_DEFAULT,
  parameter int TO_W = $clog2(TO_N),
  parameter int AN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_tvalid,
  input  logic [7:0]  str_tdata,
  output logic        str_tready,
  input  logic        str_terror_parity,
  input  logic        str_terror_fifo,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        cmd_long,
  output logic        err_drop,
  output logic        err_timeout
);

  state_t     state_reg, state_next;
  logic [1:0] arg_cnt_reg;
  logic       acc, berr, arg_last;
  logic       to_en, to_tc, to_hit, to_fire;
  logic       drop_next, timeout_next;

  assign acc      = str_tvalid & str_tready;
  assign berr     = str_terror_parity | str_terror_fifo;
  assign arg_last = (arg_cnt_reg == 2'(AN - 1));

  // Idle cycles in ARG advance the timeout; any accepted byte restarts it.
  assign to_en   = (state_reg == ST_ARG) & ~acc;
  assign to_fire = to_hit | (to_tc & to_en);

  cmd_timeout #(
    .N(TO_N),
    .W(TO_W)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(acc),
    .en (to_en),
    .tc (to_tc),
    .hit(to_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (acc && !berr) begin
          state_next = str_tdata[LONG_BIT] ? ST_ARG : ST_OUT;
        end
      end
      ST_ARG: begin
        if (acc) begin
          if (berr) begin
            state_next = ST_IDLE;
          end else if (arg_last) begin
            state_next = ST_OUT;
          end
        end else if (to_fire) begin
          state_next = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (cmd_tready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    str_tready   = (state_reg != ST_OUT);
    cmd_tvalid   = (state_reg == ST_OUT);
    drop_next    = acc & berr;
    timeout_next = to_fire;
  end

  // Command fields change only on accepted good bytes, so they stay frozen in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_opcode  <= '0;
      cmd_data    <= '0;
      cmd_long    <= 1'b0;
      arg_cnt_reg <= '0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_drop    <= drop_next;
      err_timeout <= timeout_next;
      if (acc && !berr) begin
        if (state_reg == ST_IDLE) begin
          cmd_opcode  <= str_tdata;
          cmd_data    <= '0;
          cmd_long    <= str_tdata[LONG_BIT];
          arg_cnt_reg <= '0;
        end else begin
          cmd_data[{arg_cnt_reg, 3'b000} +: 8] <= str_tdata;
          arg_cnt_reg <= arg_cnt_reg + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed scenarios plus a randomized byte stream,
// all checked against a queue-based command model.
module tb_uart_cmd_decoder;

  localparam int TO_N = 16;
  localparam int AN   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        str_tvalid = 1'b0;
  logic [7:0]  str_tdata = 8'h00;
  logic        str_tready;
  logic        str_terror_parity = 1'b0;
  logic        str_terror_fifo = 1'b0;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_long;
  logic        err_drop;
  logic        err_timeout;

  int checks = 0;
  int passes = 0;

  // Model: bytes of the command in progress, a held finished command, gap count.
  logic [7:0]  m_q[$];
  logic        m_hold = 1'b0;
  logic [7:0]  m_op = 8'h00;
  logic [31:0] m_data = 32'h0;
  logic        m_long = 1'b0;
  logic        m_drop = 1'b0;
  logic        m_to = 1'b0;
  int          m_gap = 0;

  uart_cmd_decoder #(
    .TO_N(TO_N),
    .AN  (AN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .str_tvalid       (str_tvalid),
    .str_tdata        (str_tdata),
    .str_tready       (str_tready),
    .str_terror_parity(str_terror_parity),
    .str_terror_fifo  (str_terror_fifo),
    .cmd_tvalid       (cmd_tvalid),
    .cmd_tready       (cmd_tready),
    .cmd_opcode       (cmd_opcode),
    .cmd_data         (cmd_data),
    .cmd_long         (cmd_long),
    .err_drop         (err_drop),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_hold = 1'b0;
    m_drop = 1'b0;
    m_to   = 1'b0;
    m_gap  = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_drop = 1'b0;
    m_to   = 1'b0;
    if (m_hold) begin
      if (cmd_tready) m_hold = 1'b0;
    end else if (str_tvalid) begin
      if (str_terror_parity || str_terror_fifo) begin
        m_drop = 1'b1;
        m_q.delete();
      end else begin
        m_q.push_back(str_tdata);
        m_gap = 0;
        if (!m_q[0][7] || m_q.size() == AN + 1) begin
          m_op   = m_q[0];
          m_long = m_q[0][7];
          m_data = 32'h0;
          for (int i = 1; i < m_q.size(); i++) m_data |= 32'(m_q[i]) << (8 * (i - 1));
          m_hold = 1'b1;
          m_q.delete();
        end
      end
    end else if (m_q.size() != 0) begin
      m_gap++;
      if (m_gap == TO_N - 1) begin
        m_to = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== 4'b1000)
      $display("FAIL reset_flags got %b want 1000", {str_tready, cmd_tvalid, err_drop, err_timeout});
    else passes++;
    checks++;
    if ({cmd_opcode, cmd_data, cmd_long} !== 41'h0)
      $display("FAIL reset_payload got %h/%h/%b want 0", cmd_opcode, cmd_data, cmd_long);
    else passes++;
    rst = 1'b0;
    $display("reset: flags and payload sampled");
  endtask

  task automatic test_short();
    cmd_tready = 1'b1;
    str_tvalid = 1'b1;
    str_tdata  = 8'h01;
    tick();
    str_tvalid = 1'b0;
    checks++;
    if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to})
      $display("FAIL short_flags got %b want %b", {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
    else passes++;
    checks++;
    if ({cmd_tvalid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h01, 32'h0, 1'b0})
      $display("FAIL short_payload got v=%b op=%h d=%h l=%b want v=1 op=01 d=0 l=0", cmd_tvalid, cmd_opcode, cmd_data, cmd_long);
    else passes++;
    tick();
    checks++;
    if (cmd_tvalid !== m_hold)
      $display("FAIL short_release got %b want %b", cmd_tvalid, m_hold);
    else passes++;
    $display("short: opcode 01 presented for one cycle");
  endtask

  task automatic test_long();
    logic [7:0] bytes[5] = '{8'h80, 8'h34, 8'h12, 8'hCD, 8'hAB};
    cmd_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      str_tvalid = 1'b1;
      str_tdata  = bytes[i];
      tick();
      checks++;
      if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to})
        $display("FAIL long_flags byte %0d got %b want %b", i, {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
      else passes++;
    end
    str_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({str_tready, cmd_tvalid, cmd_opcode, cmd_data, cmd_long} !== {1'b0, 1'b1, 8'h80, 32'hABCD1234, 1'b1})
        $display("FAIL long_hold cycle %0d got rdy=%b v=%b op=%h d=%h l=%b want rdy=0 v=1 op=80 d=abcd1234 l=1",
                 i, str_tready, cmd_tvalid, cmd_opcode, cmd_data, cmd_long);
      else passes++;
      tick();
    end
    cmd_tready = 1'b1;
    tick();
    cmd_tready = 1'b0;
    checks++;
    if ({str_tready, cmd_tvalid} !== {~m_hold, m_hold})
      $display("FAIL long_release got %b want %b", {str_tready, cmd_tvalid}, {~m_hold, m_hold});
    else passes++;
    $display("long: 80 abcd1234 held 10 cycles then released");
  endtask

  task automatic test_parity();
    cmd_tready = 1'b1;
    str_tvalid = 1'b1;
    str_tdata  = 8'h82;
    tick();
    str_tdata = 8'h11;
    str_terror_parity = 1'b1;
    tick();
    str_terror_parity = 1'b0;
    checks++;
    if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to} || err_drop !== 1'b1)
      $display("FAIL parity_drop got %b want %b", {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
    else passes++;
    str_tdata = 8'h02;
    tick();
    str_tvalid = 1'b0;
    checks++;
    if ({cmd_tvalid, err_drop, cmd_opcode, cmd_data, cmd_long} !== {m_hold, m_drop, m_op, m_data, m_long} || cmd_opcode !== 8'h02)
      $display("FAIL parity_resync got v=%b drop=%b op=%h d=%h l=%b want v=1 drop=0 op=02 d=0 l=0",
               cmd_tvalid, err_drop, cmd_opcode, cmd_data, cmd_long);
    else passes++;
    tick();
    $display("parity: 82 dropped, 02 decoded afterwards");
  endtask

  task automatic test_timeout();
    logic [7:0] tail[3] = '{8'h66, 8'h77, 8'h88};
    cmd_tready = 1'b1;
    str_tvalid = 1'b1;
    str_tdata  = 8'h81;
    tick();
    str_tdata = 8'h55;
    tick();
    str_tvalid = 1'b0;
    for (int i = 1; i <= TO_N - 1; i++) begin
      tick();
      checks++;
      if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to})
        $display("FAIL timeout_idle %0d got %b want %b", i, {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
      else passes++;
    end
    checks++;
    if (err_timeout !== 1'b1)
      $display("FAIL timeout_pulse got %b want 1", err_timeout);
    else passes++;
    tick();
    checks++;
    if (err_timeout !== 1'b0)
      $display("FAIL timeout_width got %b want 0", err_timeout);
    else passes++;
    str_tvalid = 1'b1;
    str_tdata  = 8'h81;
    tick();
    str_tdata = 8'h55;
    tick();
    str_tvalid = 1'b0;
    for (int i = 1; i <= TO_N - 2; i++) tick();
    for (int i = 0; i < 3; i++) begin
      str_tvalid = 1'b1;
      str_tdata  = tail[i];
      tick();
      checks++;
      if (err_timeout !== 1'b0 || err_timeout !== m_to)
        $display("FAIL timeout_race byte %0d got %b want 0", i, err_timeout);
      else passes++;
    end
    str_tvalid = 1'b0;
    checks++;
    if ({cmd_tvalid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h81, 32'h88776655, 1'b1})
      $display("FAIL timeout_race_cmd got v=%b op=%h d=%h l=%b want v=1 op=81 d=88776655 l=1",
               cmd_tvalid, cmd_opcode, cmd_data, cmd_long);
    else passes++;
    tick();
    $display("timeout: pulse after %0d idle cycles, terminal-cycle byte accepted", TO_N - 1);
  endtask

  task automatic test_reset_mid();
    cmd_tready = 1'b1;
    str_tvalid = 1'b1;
    str_tdata  = 8'h80;
    tick();
    str_tdata = 8'h11;
    tick();
    str_tdata = 8'h22;
    tick();
    str_tvalid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({str_tready, cmd_tvalid, err_drop, err_timeout, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 44'h0})
      $display("FAIL reset_mid got rdy=%b v=%b drop=%b to=%b op=%h d=%h l=%b want rdy=1 rest 0",
               str_tready, cmd_tvalid, err_drop, err_timeout, cmd_opcode, cmd_data, cmd_long);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    str_tvalid = 1'b1;
    str_tdata  = 8'h00;
    tick();
    str_tvalid = 1'b0;
    checks++;
    if ({cmd_tvalid, cmd_opcode, cmd_data, cmd_long} !== {m_hold, m_op, m_data, m_long} || cmd_tvalid !== 1'b1)
      $display("FAIL reset_mid_resume got v=%b op=%h d=%h l=%b want v=1 op=00 d=0 l=0", cmd_tvalid, cmd_opcode, cmd_data, cmd_long);
    else passes++;
    tick();
    $display("reset_mid: partial command discarded, RESET decoded");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int stalls = 0;
    cmd_tready = 1'b1;
    str_tvalid = 1'b1;
    str_tdata  = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to})
        $display("FAIL b2b_flags cycle %0d got %b want %b", i, {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
      else passes++;
      if (cmd_tvalid === 1'b1) pulses++;
      if (str_tready === 1'b0) stalls++;
    end
    str_tvalid = 1'b0;
    checks++;
    if (pulses != 5 || stalls != 5)
      $display("FAIL b2b_count got pulses=%0d stalls=%0d want 5/5", pulses, stalls);
    else passes++;
    $display("back_to_back: %0d commands, %0d stall cycles", pulses, stalls);
  endtask

  task automatic test_random();
    int idle_left = 0;
    int cmds = 0;
    for (int i = 0; i < 1500; i++) begin
      if (idle_left == 0 && $urandom_range(0, 29) == 0) idle_left = $urandom_range(8, 20);
      if (idle_left > 0) begin
        idle_left--;
        str_tvalid = 1'b0;
      end else begin
        str_tvalid = ($urandom_range(0, 9) < 7);
      end
      str_tdata         = 8'($urandom);
      str_terror_parity = ($urandom_range(0, 15) == 0);
      str_terror_fifo   = ($urandom_range(0, 15) == 0);
      cmd_tready        = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({str_tready, cmd_tvalid, err_drop, err_timeout} !== {~m_hold, m_hold, m_drop, m_to})
        $display("FAIL random_flags cycle %0d got %b want %b", i, {str_tready, cmd_tvalid, err_drop, err_timeout}, {~m_hold, m_hold, m_drop, m_to});
      else passes++;
      if (m_hold) begin
        checks++;
        if ({cmd_opcode, cmd_data, cmd_long} !== {m_op, m_data, m_long})
          $display("FAIL random_cmd cycle %0d got op=%h d=%h l=%b want op=%h d=%h l=%b",
                   i, cmd_opcode, cmd_data, cmd_long, m_op, m_data, m_long);
        else passes++;
        if (cmd_tready) cmds++;
      end
    end
    str_tvalid = 1'b0;
    str_terror_parity = 1'b0;
    str_terror_fifo = 1'b0;
    $display("random: %0d commands delivered", cmds);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
